// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, counter
// sizing and the ready-handshake timeout.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_DONE
    } state_e;

    localparam int ACK_TIMEOUT = 256;

    // One counter serves both the assert stretch and the release gap.
    function automatic int cnt_width(input int min_assert, input int release_gap);
        int longest;
        longest = (min_assert > release_gap) ? min_assert : release_gap;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/rst_req_sync.sv
// Vector multi-flop synchroniser with a synchronous active-high clear.
module rst_req_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int s = 0; s < STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Multi-channel reset sequencer: holds channels for a minimum stretch, then releases
// them in ascending order. Define RST_SEQ_ACK_EN to gate each release on RDY_IN.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_ASSERT  = 16,
    parameter int RELEASE_GAP = 8
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] RST_REQ,
    output logic [NUM_CH-1:0] RST_OUT,
    output logic              SEQ_DONE,
    output logic              BUSY
`ifdef RST_SEQ_ACK_EN
    ,
    input  logic [NUM_CH-1:0] RDY_IN,
    output logic              TIMEOUT
`endif
);

    localparam int CNT_W = cnt_width(MIN_ASSERT, RELEASE_GAP);
    localparam int IDX_W = $clog2(NUM_CH + 1);
    localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(RELEASE_GAP - 1);
    localparam logic [IDX_W-1:0] LAST_CH     = IDX_W'(NUM_CH - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  start_q, start_d;
    logic [IDX_W-1:0]  nxt_q, nxt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic [NUM_CH-1:0] req_s;
    logic [NUM_CH-1:0] req_mask;
    logic [IDX_W-1:0]  req_idx;
    logic [CNT_W-1:0]  cnt_inc;
    logic              req_any;
    logic              gap_ok;

    function automatic logic [NUM_CH-1:0] clear_ch(input logic [NUM_CH-1:0] v,
                                                    input logic [IDX_W-1:0]  idx);
        logic [NUM_CH-1:0] r;
        r = v;
        for (int k = 0; k < NUM_CH; k++) if (IDX_W'(k) == idx) r[k] = 1'b0;
        return r;
    endfunction

    rst_req_sync #(.WIDTH(NUM_CH), .STAGES(SYNC_STAGES)) u_req_sync (
        .clk_i(CLOCK), .clr_i(RESET), .d_i(RST_REQ), .q_o(req_s)
    );

`ifdef RST_SEQ_ACK_EN
    localparam int WAIT_W = $clog2(ACK_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    logic [NUM_CH-1:0] rdy_s;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              tmo_q, tmo_d;
    logic              rdy_prev;

    rst_req_sync #(.WIDTH(NUM_CH), .STAGES(SYNC_STAGES)) u_rdy_sync (
        .clk_i(CLOCK), .clr_i(RESET), .d_i(RDY_IN), .q_o(rdy_s)
    );

    // Ready of the channel just below the one waiting to be released.
    always_comb begin
        rdy_prev = 1'b0;
        for (int k = 0; k < NUM_CH; k++) if (IDX_W'(k + 1) == nxt_q) rdy_prev = rdy_s[k];
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wait_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            tmo_q  <= tmo_d;
        end
    end

    assign TIMEOUT = tmo_q;
    assign gap_ok  = (cnt_q == GAP_LAST) && (rdy_prev || (wait_q == WAIT_LAST));
`else
    assign gap_ok  = (cnt_q == GAP_LAST);
`endif

    // Lowest requesting channel and the mask of it plus all its dependents.
    always_comb begin
        req_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) if (req_s[k]) req_idx = IDX_W'(k);
        req_mask = '0;
        for (int k = 0; k < NUM_CH; k++) req_mask[k] = (IDX_W'(k) >= req_idx);
    end

    assign req_any = |req_s;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_ASSERT;
            start_q <= '0;
            nxt_q   <= '0;
            cnt_q   <= '0;
            rst_q   <= '1;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            nxt_q   <= nxt_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        nxt_d   = nxt_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
`ifdef RST_SEQ_ACK_EN
        wait_d  = '0;
        tmo_d   = 1'b0;
`endif
        unique case (state_q)
            ST_ASSERT: begin
                if (req_any) begin
                    if (req_idx < start_q) start_d = req_idx;
                    rst_d = rst_q | req_mask;
                    cnt_d = '0;
                end else if (cnt_q == ASSERT_LAST) begin
                    rst_d   = clear_ch(rst_q, start_q);
                    cnt_d   = '0;
                    nxt_d   = start_q + IDX_W'(1);
                    state_d = (start_q == LAST_CH) ? ST_DONE : ST_RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RELEASE: begin
                // Requests at or above nxt_q target channels that are still held.
                if (req_any && (req_idx < nxt_q)) begin
                    start_d = req_idx;
                    rst_d   = rst_q | req_mask;
                    cnt_d   = '0;
                    state_d = ST_ASSERT;
                end else if (gap_ok) begin
                    rst_d = clear_ch(rst_q, nxt_q);
                    cnt_d = '0;
                    nxt_d = nxt_q + IDX_W'(1);
                    if (nxt_q == LAST_CH) state_d = ST_DONE;
`ifdef RST_SEQ_ACK_EN
                    tmo_d = !rdy_prev;
`endif
                end else begin
                    if (cnt_q != GAP_LAST) cnt_d = cnt_inc;
`ifdef RST_SEQ_ACK_EN
                    if (cnt_q == GAP_LAST) wait_d = wait_q + WAIT_W'(1);
`endif
                end
            end
            ST_DONE: begin
                if (req_any) begin
                    start_d = req_idx;
                    rst_d   = rst_q | req_mask;
                    cnt_d   = '0;
                    state_d = ST_ASSERT;
                end
            end
            default: state_d = ST_ASSERT;
        endcase
    end

    always_comb begin
        SEQ_DONE = (state_q == ST_DONE);
        BUSY     = (state_q == ST_ASSERT) || (state_q == ST_RELEASE);
    end

    assign RST_OUT = rst_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed scenarios plus random soft requests, checked
// against a model that tracks the scheduled fall time of every channel.
module tb_rst_sequencer;

    localparam int NUM_CH      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int MIN_ASSERT  = 16;
    localparam int RELEASE_GAP = 8;
    localparam int HIST        = 16384;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] req = '0;
    logic [NUM_CH-1:0] rst_out;
    logic              seq_done;
    logic              busy;
`ifdef RST_SEQ_ACK_EN
    logic [NUM_CH-1:0] rdy = '1;
    logic              timeout;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_rst = -1000;
    int s = 0;
    int fall_at [NUM_CH];
    logic [NUM_CH-1:0] hist [HIST];
    logic [NUM_CH-1:0] exp_out;
    logic              exp_done;

    always #5 clk = ~clk;

    rst_sequencer #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES),
        .MIN_ASSERT(MIN_ASSERT), .RELEASE_GAP(RELEASE_GAP)
    ) dut (
        .CLOCK(clk),
        .RESET(rst),
        .RST_REQ(req),
        .RST_OUT(rst_out),
        .SEQ_DONE(seq_done),
        .BUSY(busy)
`ifdef RST_SEQ_ACK_EN
        ,
        .RDY_IN(rdy),
        .TIMEOUT(timeout)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h (edge %0d)", tag, got, exp, cyc - 1);
        end
    endtask

    // Channels s.. are scheduled to fall MIN_ASSERT after the stretch start, GAP apart.
    task automatic restart_from(input int t);
        for (int k = s; k < NUM_CH; k++) fall_at[k] = t + MIN_ASSERT + (k - s) * RELEASE_GAP;
    endtask

    task automatic model_edge();
        logic [NUM_CH-1:0] sreq;
        int m;
        hist[cyc] = req;
        if (rst) begin
            last_rst = cyc;
            s = 0;
            restart_from(cyc);
        end else begin
            sreq = '0;
            if (cyc >= SYNC_STAGES && (cyc - SYNC_STAGES) > last_rst) sreq = hist[cyc - SYNC_STAGES];
            if (sreq != '0) begin
                m = NUM_CH;
                for (int k = NUM_CH - 1; k >= 0; k--) if (sreq[k]) m = k;
                if (cyc <= fall_at[s]) begin
                    if (m < s) s = m;
                    restart_from(cyc);
                end else if (fall_at[m] < cyc) begin
                    s = m;
                    restart_from(cyc);
                end
            end
        end
        for (int k = 0; k < NUM_CH; k++) exp_out[k] = (cyc < fall_at[k]);
        exp_done = (cyc >= fall_at[NUM_CH-1]);
        cyc++;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("rst_out", 32'(rst_out), 32'(exp_out));
            chk("seq_done", 32'(seq_done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(!exp_done));
        end
    endtask

    initial begin
        // Power-up: E0 is the last edge with RESET high.
        rst = 1'b1;
        req = '0;
        step(3);
        chk("reset_out", 32'(rst_out), 32'hF);
        chk("reset_done", 32'(seq_done), 32'd0);
        chk("reset_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        step(15);
        chk("pwr_hold", 32'(rst_out), 32'hF);
        step(1);
        chk("pwr_ch0", 32'(rst_out), 32'hE);
        step(8);
        chk("pwr_ch1", 32'(rst_out), 32'hC);
        step(8);
        chk("pwr_ch2", 32'(rst_out), 32'h8);
        step(7);
        chk("pwr_ch3_wait", 32'(rst_out), 32'h8);
        chk("pwr_not_done", 32'(seq_done), 32'd0);
        step(1);
        chk("pwr_ch3", 32'(rst_out), 32'h0);
        chk("pwr_done", 32'(seq_done), 32'd1);
        step(5);

        // Soft request on channel 2 from idle.
        req = 4'b0100;
        step(1);
        req = '0;
        step(1);
        chk("soft_latency", 32'(rst_out), 32'h0);
        step(1);
        chk("soft_assert", 32'(rst_out), 32'hC);
        step(15);
        chk("soft_hold", 32'(rst_out), 32'hC);
        step(1);
        chk("soft_ch2", 32'(rst_out), 32'h8);
        step(8);
        chk("soft_ch3", 32'(rst_out), 32'h0);
        step(4);

        // Held request stretches the assertion.
        req = 4'b0010;
        step(40);
        chk("held_out", 32'(rst_out), 32'hE);
        req = '0;
        step(60);

        // Request on channel 0 after channels 0 and 1 have released.
        req = 4'b0001;
        step(1);
        req = '0;
        step(28);
        req = 4'b0001;
        step(1);
        req = '0;
        step(2);
        chk("mid_req0", 32'(rst_out), 32'hF);
        step(60);

        // Request on a still-held channel leaves the timing alone.
        req = 4'b0001;
        step(1);
        req = '0;
        step(28);
        req = 4'b1000;
        step(1);
        req = '0;
        step(2);
        chk("mid_req3", 32'(rst_out), 32'hC);
        step(50);

        // RESET during RELEASE.
        req = 4'b0001;
        step(1);
        req = '0;
        step(22);
        rst = 1'b1;
        step(1);
        chk("mid_reset_out", 32'(rst_out), 32'hF);
        chk("mid_reset_done", 32'(seq_done), 32'd0);
        rst = 1'b0;
        step(60);

        // Random soft requests and occasional master resets.
        for (int it = 0; it < 250; it++) begin
            int act;
            act = int'($urandom_range(0, 9));
            if (act == 0) begin
                rst = 1'b1;
                step(int'($urandom_range(1, 3)));
                rst = 1'b0;
            end else if (act <= 4) begin
                req = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
                step(int'($urandom_range(1, 4)));
                req = '0;
            end
            step(int'($urandom_range(1, 30)));
        end
        step(80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
